// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory initiator.
// Also holds the request fault rule that the top checks when it accepts a request.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned MEM_WORDS_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Misaligned half/word, the reserved size code, or a word index past the end of memory.
  function automatic logic req_faults(input logic [31:0] addr, input logic [1:0] size,
                                      input int unsigned mem_words);
    logic f;
    f = 1'b0;
    case (size)
      SIZE_BYTE: f = 1'b0;
      SIZE_HALF: f = addr[0];
      SIZE_WORD: f = |addr[1:0];
      default:   f = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(mem_words)) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering between a 32-bit memory word and byte/half/word accesses.
// Load path extracts and extends a lane; store path merges new data into the old word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      2'd3:    byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (size)
      SIZE_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      SIZE_WORD: load_data = word;
      default:   load_data = '0;
    endcase
  end

  always_comb begin
    store_data = word;
    case (size)
      SIZE_BYTE: begin
        case (offset)
          2'd1:    store_data[15:8]  = wdata[7:0];
          2'd2:    store_data[23:16] = wdata[7:0];
          2'd3:    store_data[31:24] = wdata[7:0];
          default: store_data[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (offset[1]) store_data[31:16] = wdata[15:0];
        else           store_data[15:0]  = wdata[15:0];
      end
      SIZE_WORD: store_data = wdata;
      default:   store_data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns byte-addressed load/store requests into word-index memory strobes.
// Sub-word stores use read-modify-write; every accepted request ends in a one-cycle response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_fault_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output state_t      dbg_state_o
);

  // Handshake: a request transfers on a posedge where req_valid_i & req_ready_o are both high;
  // req_ready_o is high only in IDLE, and resp_valid_o is a single-cycle pulse with no back-pressure.

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [1:0]  size_q;
  logic        uns_q, write_q, fault_q;
  logic        accept, accept_fault;
  logic [31:0] load_data, store_data;

  assign accept       = (state_q == ST_IDLE) && req_valid_i;
  assign accept_fault = req_faults(req_addr_i, req_size_i, MEM_WORDS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (accept_fault)                             state_d = ST_RESP;
          else if (req_write_i && req_size_i == SIZE_WORD) state_d = ST_WR;
          else                                          state_d = ST_RD;
        end
      end
      ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      word_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        write_q <= req_write_i;
        fault_q <= accept_fault;
      end
      // Memory presents the word on the negedge inside RD; sample it as RD ends.
      if (state_q == ST_RD) word_q <= mem_rdata_i;
    end
  end

  mem_lane_align u_align (
    .word        (word_q),
    .wdata       (wdata_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  assign req_ready_o  = (state_q == ST_IDLE);
  assign MemRead_o    = (state_q == ST_RD);
  assign MemWrite_o   = (state_q == ST_WR);
  assign mem_addr_o   = {2'b00, addr_q[31:2]};
  assign mem_wdata_o  = (state_q == ST_WR) ? store_data : '0;
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_fault_o = (state_q == ST_RESP) && fault_q;
  assign resp_rdata_o = ((state_q == ST_RESP) && !fault_q && !write_q) ? load_data : '0;
  assign dbg_state_o  = state_q;

endmodule
